pu_sequencer: RTL and testbench
===============================

Name: pu_sequencer

Overview:
Initiator-side controller for the 4-input processing unit (PU).
- Buffers four activations and four weights, written one 32-bit word at a time from the upstream loader.
- On `start`, drives the PU operand buses and generates the `ldM`/`ldRes` load strobes with correct timing.
- Captures the PU's `aOut` result and returns it upstream over a valid/ready handshake.
- Sits between the layer controller/memory loader and one PU instance.

Parameters:
- ADD_WAIT, 1, cycles from the `ldM` strobe to the `ldRes` strobe, for adder-tree settling; legal range 1..15.
- WIDTH, 32, data word width; IEEE-754 single precision.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- wr_en  input  1  operand write strobe.
- wr_addr  input  3  operand index: 0-3 = a1-a4, 4-7 = w1-w4.
- wr_data  input  WIDTH  operand value.
- start  input  1  launch one PU computation.
- busy  output  1  high whenever the FSM is not in IDLE.
- wr_err  output  1  sticky; set by a write or start attempted while busy.
- err_clr  input  1  clears wr_err.
- ldM  output  1  PU multiply-register load strobe.
- ldRes  output  1  PU result-register load strobe.
- a1, a2, a3, a4  output  WIDTH  activation operands to the PU.
- w1, w2, w3, w4  output  WIDTH  weight operands to the PU.
- aOut  input  WIDTH  PU result.
- res_valid  output  1  result available.
- res_ready  input  1  upstream accepts the result.
- res_data  output  WIDTH  captured result.

Behaviour:
- Reset (rst=0, asynchronous):
  - All eight operand registers, res_data and wr_err clear to 0.
  - FSM goes to IDLE.
  - ldM, ldRes, busy and res_valid are 0.
- Operand registers:
  - Written on a clock edge with wr_en=1 only while in IDLE.
  - Drive a1..a4 and w1..w4 continuously.
  - Writes are blocked while busy, so operands stay stable for the whole job.
- Blocked operations:
  - wr_en=1 while busy is ignored and sets wr_err.
  - start=1 while busy is ignored and sets wr_err.
  - err_clr=1 clears wr_err. If err_clr and a new error occur in the same cycle, the set wins.
- FSM states: IDLE, LDM, SUM, CAP, DONE.
  - IDLE: start=1 -> LDM. If wr_en and start occur in the same cycle, the write commits on that edge and the job uses the new value.
  - LDM: one cycle, ldM=1 (combinational from state) -> SUM. Load the down-counter with ADD_WAIT-1.
  - SUM: lasts ADD_WAIT cycles. ldRes=1 during the final SUM cycle only (counter==0) -> CAP.
  - CAP: one cycle; res_data <= aOut at the end of the cycle -> DONE.
  - DONE: res_valid=1 and res_data held stable. res_ready=1 -> IDLE on that edge.
- Strobes:
  - ldM and ldRes are never high simultaneously.
  - Each is high for exactly one cycle per job.
- Latency:
  - res_valid rises ADD_WAIT+2 edges after the edge that samples start; with the default, 3 edges.
  - Minimum job-to-job period is ADD_WAIT+4 cycles.
- Handshake:
  - res_valid is held until res_ready is seen.
  - res_ready while res_valid=0 has no effect.
  - A start in the same cycle as the consuming res_ready is ignored (still busy) and sets wr_err.
- Reset mid-job: immediate return to IDLE, strobes drop asynchronously, the partial result is discarded.
- Result policy: res_data is whatever the PU reports. The sequencer performs no arithmetic and does not re-check the sign of aOut.

Test Plan:
- Basic job:
  - Stimulus: reset, then write a1..a4 = 0x3F800000, 0x40000000, 0x40400000, 0x40800000 and w1..w4 = 0x3F800000 (1.0); pulse start; PU model attached.
  - Required response: ldM 1 cycle after start; ldRes 1 cycle later; res_valid after 3 edges; res_data = 0x41200000 (10.0).
- Negative sum:
  - Stimulus: w1..w4 = 0xBF800000 (-1.0), same activations.
  - Required response: PU clamps; res_data = 0x00000000 and res_valid still asserts.
- ADD_WAIT=4:
  - Stimulus: run a job with ADD_WAIT=4.
  - Required response: 4 cycles between the ldM pulse and the end of the ldRes pulse; ldRes only in the 4th SUM cycle; res_valid after 6 edges.
- Backpressure:
  - Stimulus: hold res_ready=0 for 10 cycles, and attempt a write to addr 2 plus a start during that time.
  - Required response: res_data stable; busy=1; a3 unchanged; wr_err=1; after res_ready=1, IDLE next cycle. err_clr then clears wr_err.
- Same-cycle write and start:
  - Stimulus: in IDLE, write addr 7 = 0x40000000 with start in the same cycle.
  - Required response: the job uses w4 = 2.0.
- Reset mid-job:
  - Stimulus: deassert rst during SUM.
  - Required response: ldRes never pulses; busy=0, res_valid=0 and operands=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/pu_sequencer.sv
// Initiator-side sequencer for one 4-input PU: buffers operands, strobes ldM/ldRes,
// captures aOut and hands the result upstream over valid/ready.
module pu_sequencer #(
  parameter int ADD_WAIT = 1,
  parameter int WIDTH    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  output logic             busy,
  output logic             wr_err,
  input  logic             err_clr,
  output logic             ldM,
  output logic             ldRes,
  output logic [WIDTH-1:0] a1,
  output logic [WIDTH-1:0] a2,
  output logic [WIDTH-1:0] a3,
  output logic [WIDTH-1:0] a4,
  output logic [WIDTH-1:0] w1,
  output logic [WIDTH-1:0] w2,
  output logic [WIDTH-1:0] w3,
  output logic [WIDTH-1:0] w4,
  input  logic [WIDTH-1:0] aOut,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LDM  = 3'd1;
  localparam logic [2:0] SUM  = 3'd2;
  localparam logic [2:0] CAP  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]       state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] op [8];
  logic             wr_ok;

  // Strobes decode straight from state so an async reset drops them at once.
  assign busy      = (state != IDLE);
  assign ldM       = (state == LDM);
  assign ldRes     = (state == SUM) && (cnt == 4'd0);
  assign res_valid = (state == DONE);
  assign wr_ok     = wr_en && !busy;

  genvar i;
  generate
    for (i = 0; i < 8; i++) begin : g_op
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           op[i] <= '0;
        else if (wr_ok && wr_addr == 3'(i)) op[i] <= wr_data;
      end
    end
  endgenerate

  assign a1 = op[0];
  assign a2 = op[1];
  assign a3 = op[2];
  assign a4 = op[3];
  assign w1 = op[4];
  assign w2 = op[5];
  assign w3 = op[6];
  assign w4 = op[7];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      res_data <= '0;
    end else begin
      case (state)
        IDLE: if (start) state <= LDM;
        LDM: begin
          cnt   <= 4'(ADD_WAIT - 1);
          state <= SUM;
        end
        SUM: begin
          if (cnt == 4'd0) state <= CAP;
          else             cnt   <= cnt - 4'd1;
        end
        CAP: begin
          res_data <= aOut;
          state    <= DONE;
        end
        DONE: if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A fresh error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          wr_err <= 1'b0;
    else if (busy && (wr_en || start)) wr_err <= 1'b1;
    else if (err_clr)                  wr_err <= 1'b0;
  end

endmodule

// File: tb/tb_pu_sequencer.sv
// Directed bench for pu_sequencer: default-latency DUT plus an ADD_WAIT=4 DUT,
// each driving a table-based PU model that registers on ldM and ldRes.
module tb_pu_sequencer;

  logic        clk = 1'b0;
  logic        rst, wr_en, start, err_clr, res_ready, start4, res_ready4;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;

  logic        busy, wr_err, ldM, ldRes, res_valid;
  logic [31:0] op [8];
  logic [31:0] aOut, res_data;
  logic        busy4, wr_err4, ldM4, ldRes4, res_valid4;
  logic [31:0] op4 [8];
  logic [31:0] aOut4, res_data4;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  pu_sequencer #(.ADD_WAIT(1), .WIDTH(32)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .wr_err(wr_err), .err_clr(err_clr),
    .ldM(ldM), .ldRes(ldRes),
    .a1(op[0]), .a2(op[1]), .a3(op[2]), .a4(op[3]),
    .w1(op[4]), .w2(op[5]), .w3(op[6]), .w4(op[7]),
    .aOut(aOut), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data));

  pu_sequencer #(.ADD_WAIT(4), .WIDTH(32)) dut4 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start4), .busy(busy4), .wr_err(wr_err4), .err_clr(err_clr),
    .ldM(ldM4), .ldRes(ldRes4),
    .a1(op4[0]), .a2(op4[1]), .a3(op4[2]), .a4(op4[3]),
    .w1(op4[4]), .w2(op4[5]), .w3(op4[6]), .w4(op4[7]),
    .aOut(aOut4), .res_valid(res_valid4), .res_ready(res_ready4), .res_data(res_data4));

  // PU stand-in: known operand sets map to hand-computed single-precision results.
  function automatic logic [31:0] pu_calc(input logic [31:0] o [8]);
    logic [31:0] r;
    r = 32'hEEEE_EEEE;
    if (o[0] == 32'h3F800000 && o[1] == 32'h40000000 &&
        o[2] == 32'h40400000 && o[3] == 32'h40800000) begin
      if (o[4] == 32'h3F800000 && o[5] == 32'h3F800000 && o[6] == 32'h3F800000) begin
        if (o[7] == 32'h3F800000)      r = 32'h41200000;  // 10.0
        else if (o[7] == 32'h40000000) r = 32'h41600000;  // 14.0
      end else if (o[4] == 32'hBF800000 && o[5] == 32'hBF800000 &&
                   o[6] == 32'hBF800000 && o[7] == 32'hBF800000) r = 32'h0;  // -10 clamps
    end
    return r;
  endfunction

  logic [31:0] m_q = '0, m4_q = '0;
  logic [31:0] pu_q = '0, pu4_q = '0;
  assign aOut  = pu_q;
  assign aOut4 = pu4_q;

  always @(posedge clk) begin
    if (ldM) begin m_q <= pu_calc(op); pu_q <= '0; end
    else if (ldRes) pu_q <= m_q;
    if (ldM4) begin m4_q <= pu_calc(op4); pu4_q <= '0; end
    else if (ldRes4) pu4_q <= m4_q;
  end

  task automatic write_op(input logic [2:0] addr, input logic [31:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vecs++; if (ldM !== 1'b0 || ldRes !== 1'b0) begin errs++; $display("FAIL reset_strobes got %b%b want 00", ldM, ldRes); end
    vecs++; if (res_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", res_valid); end
    vecs++; if (wr_err !== 1'b0) begin errs++; $display("FAIL reset_err got %b want 0", wr_err); end
    vecs++; if (res_data !== 32'h0) begin errs++; $display("FAIL reset_data got %h want 0", res_data); end
    for (int i = 0; i < 8; i++) begin
      vecs++; if (op[i] !== 32'h0) begin errs++; $display("FAIL reset_op%0d got %h want 0", i, op[i]); end
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [31:0] acts [4];
    acts = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    for (int i = 0; i < 4; i++) write_op(3'(i), acts[i]);
    for (int i = 4; i < 8; i++) write_op(3'(i), 32'h3F800000);
    vecs++; if (op[2] !== 32'h40400000) begin errs++; $display("FAIL basic_a3 got %h want 40400000", op[2]); end
    start = 1'b1; @(negedge clk); start = 1'b0;
    vecs++; if (ldM !== 1'b1 || ldRes !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL basic_ldm got ldM=%b ldRes=%b busy=%b want 1 0 1", ldM, ldRes, busy); end
    @(negedge clk);
    vecs++; if (ldRes !== 1'b1 || ldM !== 1'b0) begin errs++; $display("FAIL basic_ldres got ldM=%b ldRes=%b want 0 1", ldM, ldRes); end
    @(negedge clk);
    vecs++; if (res_valid !== 1'b0 || ldRes !== 1'b0) begin errs++; $display("FAIL basic_cap got valid=%b ldRes=%b want 0 0", res_valid, ldRes); end
    @(negedge clk);
    vecs++; if (res_valid !== 1'b1) begin errs++; $display("FAIL basic_valid got %b want 1", res_valid); end
    vecs++; if (res_data !== 32'h41200000) begin errs++; $display("FAIL basic_data got %h want 41200000", res_data); end
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    vecs++; if (busy !== 1'b0 || res_valid !== 1'b0) begin errs++; $display("FAIL basic_idle got busy=%b valid=%b want 0 0", busy, res_valid); end
  endtask

  task automatic test_add_wait4;
    start4 = 1'b1; @(negedge clk); start4 = 1'b0;
    vecs++; if (ldM4 !== 1'b1) begin errs++; $display("FAIL aw4_ldm got %b want 1", ldM4); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vecs++; if (ldM4 !== 1'b0 || ldRes4 !== (k == 3)) begin errs++; $display("FAIL aw4_sum%0d got ldM=%b ldRes=%b want 0 %b", k, ldM4, ldRes4, (k == 3)); end
    end
    @(negedge clk);
    vecs++; if (res_valid4 !== 1'b0 || ldRes4 !== 1'b0) begin errs++; $display("FAIL aw4_cap got valid=%b ldRes=%b want 0 0", res_valid4, ldRes4); end
    @(negedge clk);
    vecs++; if (res_valid4 !== 1'b1 || res_data4 !== 32'h41200000) begin errs++; $display("FAIL aw4_done got valid=%b data=%h want 1 41200000", res_valid4, res_data4); end
    res_ready4 = 1'b1; @(negedge clk); res_ready4 = 1'b0;
    vecs++; if (busy4 !== 1'b0) begin errs++; $display("FAIL aw4_idle got busy=%b want 0", busy4); end
  endtask

  task automatic test_negative;
    for (int i = 4; i < 8; i++) write_op(3'(i), 32'hBF800000);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    vecs++; if (res_valid !== 1'b1 || res_data !== 32'h0) begin errs++; $display("FAIL neg_result got valid=%b data=%h want 1 00000000", res_valid, res_data); end
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    for (int i = 4; i < 8; i++) write_op(3'(i), 32'h3F800000);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      wr_en = (k == 2); wr_addr = 3'd2; wr_data = 32'h12345678;
      start = (k == 5); err_clr = (k == 5);
      @(negedge clk);
      vecs++; if (res_valid !== 1'b1 || busy !== 1'b1 || res_data !== 32'h41200000) begin errs++; $display("FAIL bp_hold%0d got valid=%b busy=%b data=%h want 1 1 41200000", k, res_valid, busy, res_data); end
      vecs++; if (op[2] !== 32'h40400000) begin errs++; $display("FAIL bp_a3_%0d got %h want 40400000", k, op[2]); end
      vecs++; if (wr_err !== (k >= 2)) begin errs++; $display("FAIL bp_err%0d got %b want %b", k, wr_err, (k >= 2)); end
    end
    wr_en = 1'b0; start = 1'b0; err_clr = 1'b0;
    res_ready = 1'b1; start = 1'b1; @(negedge clk); res_ready = 1'b0; start = 1'b0;
    vecs++; if (busy !== 1'b0 || res_valid !== 1'b0 || wr_err !== 1'b1) begin errs++; $display("FAIL bp_release got busy=%b valid=%b err=%b want 0 0 1", busy, res_valid, wr_err); end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    vecs++; if (wr_err !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL bp_errclr got err=%b busy=%b want 0 0", wr_err, busy); end
  endtask

  task automatic test_same_cycle;
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 32'h40000000; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    vecs++; if (op[7] !== 32'h40000000 || ldM !== 1'b1) begin errs++; $display("FAIL same_w4 got w4=%h ldM=%b want 40000000 1", op[7], ldM); end
    repeat (3) @(negedge clk);
    vecs++; if (res_valid !== 1'b1 || res_data !== 32'h41600000) begin errs++; $display("FAIL same_result got valid=%b data=%h want 1 41600000", res_valid, res_data); end
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic seen;
    seen = 1'b0;
    start4 = 1'b1; @(negedge clk); start4 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    vecs++; if (busy4 !== 1'b0 || ldRes4 !== 1'b0 || ldM4 !== 1'b0 || res_valid4 !== 1'b0) begin errs++; $display("FAIL rmid_async got busy=%b ldM=%b ldRes=%b valid=%b want 0 0 0 0", busy4, ldM4, ldRes4, res_valid4); end
    vecs++; if (op4[0] !== 32'h0 || op4[7] !== 32'h0 || op[7] !== 32'h0) begin errs++; $display("FAIL rmid_ops got a1=%h w4=%h w4_dut1=%h want 0 0 0", op4[0], op4[7], op[7]); end
    repeat (3) begin @(negedge clk); seen = seen | ldRes4; end
    rst = 1'b1;
    repeat (5) begin @(negedge clk); seen = seen | ldRes4; end
    vecs++; if (seen !== 1'b0 || busy4 !== 1'b0) begin errs++; $display("FAIL rmid_after got ldRes_seen=%b busy=%b want 0 0", seen, busy4); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    err_clr = 1'b0; res_ready = 1'b0; start4 = 1'b0; res_ready4 = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    test_basic;
    test_add_wait4;
    test_negative;
    test_backpressure;
    test_same_cycle;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
